reg32_serial_reader: RTL and testbench



---
 rtl/reg_rd_pkg.sv | 20 ++
 rtl/reg32_serial_reader_tick_gen.sv | 31 +++
 rtl/reg32_serial_reader.sv | 125 ++++++++++++
 tb/tb_reg32_serial_reader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/reg_rd_pkg.sv
// Shared types and constants for the 32-bit register serial readback unit.
package reg_rd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } rd_state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DIV   = 2;
  localparam logic        OUT_RST   = 1'b0;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg32_serial_reader_tick_gen.sv
// DIV-cycle phase counter: one-cycle tick every DIV cycles, restarted by clear.
module tick_gen
  import reg_rd_pkg::*;
#(
  parameter int unsigned DIV = DEF_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned PW = cnt_w(DIV);

  logic [PW-1:0] r_phase;
  logic          w_tick;

  assign w_tick = !i_clr && (r_phase == PW'(DIV - 1));
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (i_clr || w_tick) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/reg32_serial_reader.sv
// Snapshots a register word on start and shifts it out MSB-first on a
// clock/data/latch serial link.
module reg32_serial_reader
  import reg_rd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch
);

  localparam int unsigned BW = $clog2(WIDTH) + 1;

  rd_state_e        r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_shadow, w_shadow_nxt;
  logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_sclk,   w_sclk_nxt;
  logic             r_sdata,  w_sdata_nxt;
  logic             r_slatch, w_slatch_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_tick;
  logic             w_clr;

  // Phase restarts on every acceptance because the counter is held clear in IDLE.
  assign w_clr     = (r_state == IDLE);
  assign w_shifted = r_shadow << 1;

  tick_gen #(.DIV(DIV)) u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_bitcnt_nxt = r_bitcnt;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_sclk_nxt   = r_sclk;
    w_sdata_nxt  = r_sdata;
    w_slatch_nxt = r_slatch;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = SHIFT_LO;
          w_shadow_nxt = D;
          w_bitcnt_nxt = '0;
          w_busy_nxt   = 1'b1;
          w_sdata_nxt  = D[WIDTH-1];
        end
      end
      SHIFT_LO: begin
        if (w_tick) begin
          w_sclk_nxt  = 1'b1;
          w_state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_tick) begin
          w_sclk_nxt   = 1'b0;
          w_shadow_nxt = w_shifted;
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == BW'(WIDTH - 1)) begin
            w_state_nxt  = LATCH;
            w_sdata_nxt  = 1'b0;
            w_slatch_nxt = 1'b1;
          end else begin
            w_state_nxt  = SHIFT_LO;
            w_sdata_nxt  = w_shifted[WIDTH-1];
          end
        end
      end
      LATCH: begin
        if (w_tick) begin
          w_slatch_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_bitcnt <= '0;
      r_busy   <= OUT_RST;
      r_done   <= OUT_RST;
      r_sclk   <= OUT_RST;
      r_sdata  <= OUT_RST;
      r_slatch <= OUT_RST;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_sclk   <= w_sclk_nxt;
      r_sdata  <= w_sdata_nxt;
      r_slatch <= w_slatch_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign sclk   = r_sclk;
  assign sdata  = r_sdata;
  assign slatch = r_slatch;

endmodule

// File: tb/tb_reg32_serial_reader.sv
// Bench for reg32_serial_reader: default 32-bit/DIV=2 instance and an 8-bit/DIV=1 instance.
module tb_reg32_serial_reader;

  logic        clk;
  logic        rst_n;
  logic        st0, st1;
  logic [31:0] d0;
  logic [7:0]  d1;
  logic        busy0, done0, sclk0, sdata0, slatch0;
  logic        busy1, done1, sclk1, sdata1, slatch1;
  logic        sel;
  logic        o_busy, o_done, o_sclk, o_sdata, o_slatch;
  int          total;
  int          bad;

  reg32_serial_reader dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .D(d0),
    .busy(busy0), .done(done0), .sclk(sclk0), .sdata(sdata0), .slatch(slatch0)
  );

  reg32_serial_reader #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .D(d1),
    .busy(busy1), .done(done1), .sclk(sclk1), .sdata(sdata1), .slatch(slatch1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_busy   = sel ? busy1   : busy0;
    o_done   = sel ? done1   : done0;
    o_sclk   = sel ? sclk1   : sclk0;
    o_sdata  = sel ? sdata1  : sdata0;
    o_slatch = sel ? slatch1 : slatch0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [31:0] d);
    if (sel) d1 = d[7:0];
    else     d0 = d;
  endtask

  task automatic set_start(input logic s);
    if (sel) st1 = s;
    else     st0 = s;
  endtask

  // Called just after the acceptance edge; follows one transfer to its done pulse.
  task automatic monitor(input int W, input int DV, input logic [31:0] d,
                         input bit chgd, input bit hold);
    logic [31:0] got;
    logic [31:0] mask;
    logic        psclk, psdata;
    int          rises, lat, done_at;
    bit          ok_edge;
    chk("busy_rise", {31'd0, o_busy}, 32'd1);
    chk("first_bit", {31'd0, o_sdata}, {31'd0, d[W-1]});
    got = '0; rises = 0; lat = 0; done_at = -1; ok_edge = 1'b1;
    psclk = o_sclk; psdata = o_sdata;
    @(negedge clk);
    if (!hold) set_start(1'b0);
    if (chgd) set_d(32'd0);
    for (int n = 1; n <= 2*DV*W + DV + 8 && done_at < 0; n++) begin
      @(posedge clk); #1;
      if (o_sclk && !psclk) begin
        chk("rise_time", n, DV + 2*DV*rises);
        got = {got[30:0], o_sdata};
        rises++;
      end
      if (o_sdata !== psdata && !(psclk && !o_sclk)) ok_edge = 1'b0;
      if (o_slatch) lat++;
      if (o_done) done_at = n;
      psclk = o_sclk; psdata = o_sdata;
    end
    mask = (W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << W) - 32'd1);
    chk("nrises", rises, W);
    chk("word", got & mask, d & mask);
    chk("sdata_on_fall", {31'd0, ok_edge}, 32'd1);
    chk("latch_len", lat, DV);
    chk("done_at", done_at, 2*DV*W + DV);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, o_done}, 32'd0);
    chk("busy_after", {31'd0, o_busy}, {31'd0, hold});
  endtask

  task automatic xfer(input int W, input int DV, input logic [31:0] d,
                      input bit chgd, input bit hold);
    @(negedge clk);
    set_d(d);
    set_start(1'b1);
    @(posedge clk); #1;
    monitor(W, DV, d, chgd, hold);
    if (hold) monitor(W, DV, d, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] rnd;
    logic        psclk;
    int          rises, n;
    bit          seen;
    total = 0; bad = 0;
    sel = 1'b0; rst_n = 1'b0;
    st0 = 1'b0; st1 = 1'b0; d0 = '0; d1 = '0;
    #1;
    chk("rst_outs0", {27'd0, busy0, done0, sclk0, sdata0, slatch0}, 32'd0);
    chk("rst_outs1", {27'd0, busy1, done1, sclk1, sdata1, slatch1}, 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;

    xfer(32, 2, 32'h8000_0001, 1'b0, 1'b0);
    xfer(32, 2, 32'hA5A5_5AA5, 1'b1, 1'b0);
    xfer(32, 2, $urandom, 1'b0, 1'b1);
    repeat (3) xfer(32, 2, $urandom, 1'b0, 1'b0);

    // Reset in the middle of a transfer, around bit 10.
    rnd = $urandom;
    @(negedge clk); set_d(rnd); set_start(1'b1);
    @(posedge clk); #1;
    psclk = o_sclk;
    @(negedge clk); set_start(1'b0);
    rises = 0; n = 0;
    while (rises < 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (o_sclk && !psclk) rises++;
      psclk = o_sclk;
    end
    chk("reach_bit10", rises, 10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {27'd0, o_busy, o_done, o_sclk, o_sdata, o_slatch}, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_done) seen = 1'b1;
    end
    chk("no_done_rst", {31'd0, seen}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    xfer(32, 2, 32'hFFFF_FFFF, 1'b0, 1'b0);

    sel = 1'b1;
    xfer(8, 1, 32'h3C, 1'b0, 1'b0);
    repeat (4) xfer(8, 1, $urandom, 1'b0, 1'b0);
    xfer(8, 1, $urandom, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
